// File: rtl/uart_boot_pkg.sv
// rtl/uart_boot_pkg.sv - shared constants for the UART boot loader
package uart_boot_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_LO = 3'd1;
    localparam logic [2:0] ST_CNT_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_ACK    = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

    localparam int WORD_W = 32;

endpackage

// File: rtl/uart_boot_timer.sv
// rtl/uart_boot_timer.sv - inter-byte idle timeout counter
module uart_boot_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // Count idle cycles while enabled; saturate at the limit, clear on demand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - serial program image loader into instruction memory
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] HDR_BYTE    = DEF_HDR_BYTE,
    parameter logic [7:0] ERR_BYTE    = DEF_ERR_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

    logic [2:0]        state;
    logic [7:0]        byte_q;
    logic [7:0]        cnt_lo;
    logic [15:0]       word_cnt;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        checksum;

    logic fetch_st;
    logic launch;
    logic expired;
    logic last_word;
    logic [15:0] n_rx;

    assign fetch_st  = (state == ST_IDLE) || (state == ST_CNT_LO) ||
                       (state == ST_CNT_HI) || (state == ST_DATA);
    // rd_uart is the previous launch, so a launch is never back-to-back with a pop.
    assign launch    = fetch_st && !rx_empty && !rd_uart;
    assign n_rx      = {byte_q, cnt_lo};
    assign last_word = ((17'(addr) + 17'd1) == {1'b0, word_cnt});

    uart_boot_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (rd_uart || (state == ST_IDLE)),
        .enable  ((state == ST_CNT_LO) || (state == ST_CNT_HI) || (state == ST_DATA)),
        .expired (expired)
    );

    // Latch the FIFO head and pulse the pop; the byte is consumed while rd_uart is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_uart <= 1'b0;
            byte_q  <= '0;
        end else begin
            rd_uart <= launch;
            if (launch) begin
                byte_q <= r_data;
            end
        end
    end

    // Frame FSM with byte assembler, checksum and word address counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt_lo   <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            word     <= '0;
            addr     <= '0;
            checksum <= '0;
            cpu_hold <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_uart && (byte_q == HDR_BYTE)) begin
                        state    <= ST_CNT_LO;
                        cpu_hold <= 1'b1;
                        checksum <= '0;
                        addr     <= '0;
                        byte_idx <= '0;
                    end
                end
                ST_CNT_LO: begin
                    if (rd_uart) begin
                        cnt_lo <= byte_q;
                        state  <= ST_CNT_HI;
                    end else if (expired && !launch) begin
                        state <= ST_ERR;
                    end
                end
                ST_CNT_HI: begin
                    if (rd_uart) begin
                        word_cnt <= n_rx;
                        if ({1'b0, n_rx} > MAX_WORDS) begin
                            state <= ST_ERR;
                        end else if (n_rx == 16'd0) begin
                            state <= ST_ACK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else if (expired && !launch) begin
                        state <= ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (rd_uart) begin
                        word     <= {byte_q, word[WORD_W-1:8]};
                        checksum <= checksum ^ byte_q;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state <= ST_WRITE;
                        end
                    end else if (expired && !launch) begin
                        state <= ST_ERR;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
                        state <= ST_ACK;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= ST_DATA;
                    end
                end
                ST_ACK, ST_ERR: begin
                    if (!tx_full) begin
                        state    <= ST_IDLE;
                        cpu_hold <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_we    = (state == ST_WRITE);
    assign imem_addr  = addr;
    assign imem_wdata = word;
    assign load_done  = (state == ST_ACK) && !tx_full;
    assign load_err   = (state == ST_ERR) && !tx_full;
    assign wr_uart    = load_done || load_err;
    assign w_data     = (state == ST_ERR) ? ERR_BYTE :
                        (state == ST_ACK) ? checksum : 8'h00;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic        tx_full = 1'b0;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  frame[$];
    logic [31:0] mem [0:1023];
    int we_cnt = 0;
    int done_cnt = 0;
    int lerr_cnt = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int we_lat = -1;
    logic prev_rd = 1'b0;

    uart_boot_loader #(.ADDR_W(10), .TIMEOUT_CYC(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // UART FIFO model and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rd_uart) begin
            chk("rd_consecutive", 32'(prev_rd), 32'd0);
            chk("rd_while_empty", 32'(rx_empty), 32'd0);
            if (rxq.size() != 0) void'(rxq.pop_front());
            rx_empty = (rxq.size() == 0);
            r_data   = rx_empty ? 8'h00 : rxq[0];
            last_pop_cyc = cyc;
        end
        prev_rd = rd_uart;
        if (wr_uart) begin
            chk("wr_while_full", 32'(tx_full), 32'd0);
            txq.push_back(w_data);
        end
        if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            we_cnt++;
            we_lat = cyc - last_pop_cyc;
        end
        if (load_done) done_cnt++;
        if (load_err) lerr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_frame();
        foreach (frame[i]) begin
            rxq.push_back(frame[i]);
        end
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic clr();
        we_cnt = 0;
        done_cnt = 0;
        lerr_cnt = 0;
        txq.delete();
    endtask

    task automatic wait_end(input int maxc, input string tag);
        int n = 0;
        while ((done_cnt + lerr_cnt) == 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 32'((done_cnt + lerr_cnt) != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_uart", 32'(rd_uart), 32'd0);
        chk("rst_wr_uart", 32'(wr_uart), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1) two-word image
        clr();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame();
        wait_end(400, "t1_end");
        chk("t1_mem0", mem[0], 32'h44332211);
        chk("t1_mem1", mem[1], 32'h88776655);
        chk("t1_we_cnt", 32'(we_cnt), 32'd2);
        chk("t1_we_latency", 32'(we_lat), 32'd1);
        chk("t1_tx_cnt", 32'(txq.size()), 32'd1);
        chk("t1_tx_byte", 32'(txq.size() > 0 ? txq[0] : 8'hXX), 32'h88);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_err", 32'(lerr_cnt), 32'd0);
        chk("t1_hold_low", 32'(cpu_hold), 32'd0);

        // 2) junk before header, zero-length frame
        clr();
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        send_frame();
        wait_end(400, "t2_end");
        chk("t2_we_cnt", 32'(we_cnt), 32'd0);
        chk("t2_tx_byte", 32'(txq.size() > 0 ? txq[0] : 8'hXX), 32'h00);
        chk("t2_done", 32'(done_cnt), 32'd1);
        chk("t2_rx_drained", 32'(rxq.size()), 32'd0);

        // 3) word count 1025 exceeds memory
        clr();
        frame = '{8'hA5, 8'h01, 8'h04};
        send_frame();
        wait_end(400, "t3_end");
        chk("t3_we_cnt", 32'(we_cnt), 32'd0);
        chk("t3_tx_byte", 32'(txq.size() > 0 ? txq[0] : 8'hXX), 32'hEE);
        chk("t3_err", 32'(lerr_cnt), 32'd1);
        chk("t3_done", 32'(done_cnt), 32'd0);

        // 3b) word count 1024 is accepted, then stalls into a timeout
        clr();
        frame = '{8'hA5, 8'h00, 8'h04};
        send_frame();
        repeat (20) @(posedge clk);
        #1;
        chk("t3b_no_err", 32'(lerr_cnt), 32'd0);
        chk("t3b_hold", 32'(cpu_hold), 32'd1);
        wait_end(400, "t3b_end");
        chk("t3b_err", 32'(lerr_cnt), 32'd1);

        // 4) timeout inside data
        clr();
        frame = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
        send_frame();
        repeat (30) @(posedge clk);
        #1;
        chk("t4_waiting", 32'(lerr_cnt), 32'd0);
        wait_end(400, "t4_end");
        chk("t4_tx_byte", 32'(txq.size() > 0 ? txq[0] : 8'hXX), 32'hEE);
        chk("t4_err", 32'(lerr_cnt), 32'd1);
        chk("t4_we_cnt", 32'(we_cnt), 32'd0);
        chk("t4_hold_low", 32'(cpu_hold), 32'd0);

        // 5) TX back-pressure in ACK
        clr();
        tx_full = 1'b1;
        frame = '{8'hA5, 8'h01, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h1D};
        send_frame();
        for (int n = 0; n < 200 && we_cnt == 0; n++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_held_tx", 32'(txq.size()), 32'd0);
        chk("t5_held_hold", 32'(cpu_hold), 32'd1);
        chk("t5_held_done", 32'(done_cnt), 32'd0);
        tx_full = 1'b0;
        wait_end(50, "t5_end");
        chk("t5_tx_cnt", 32'(txq.size()), 32'd1);
        chk("t5_tx_byte", 32'(txq.size() > 0 ? txq[0] : 8'hXX), 32'h10);
        chk("t5_mem0", mem[0], 32'h1D0C0B0A);

        // 6) reset during data of a two-word frame, then a fresh frame
        clr();
        frame = '{8'hA5, 8'h02, 8'h00, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6};
        send_frame();
        for (int n = 0; n < 200 && we_cnt == 0; n++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_partial_mem0", mem[0], 32'hF4F3F2F1);
        chk("t6_pre_hold", 32'(cpu_hold), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_hold", 32'(cpu_hold), 32'd0);
        chk("t6_rst_rd", 32'(rd_uart), 32'd0);
        chk("t6_rst_wr", 32'(wr_uart), 32'd0);
        chk("t6_rst_we", 32'(imem_we), 32'd0);
        rxq.delete();
        rx_empty = 1'b1;
        r_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clr();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame();
        wait_end(400, "t6_end");
        chk("t6_mem0", mem[0], 32'h04030201);
        chk("t6_we_cnt", 32'(we_cnt), 32'd1);
        chk("t6_tx_byte", 32'(txq.size() > 0 ? txq[0] : 8'hXX), 32'h04);
        chk("t6_done", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
